ps2_key_fifo: RTL

PS/2 keyboard front end for the THCO CPU: receives scan-code set 2 frames from the ps2clk/ps2data pins, tracks make/break/shift state, translates make codes to 7-bit ASCII and buffers them in a small FIFO. It sits directly upstream of the MMU keyboard port. The MMU reads the head entry through `data`/`status` and consumes it with a one-cycle `pop`. All logic runs on the CPU main clock.

---
 rtl/ps2_key_fifo.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo -- PS/2 keyboard front end for the THCO CPU.
// Receives scan-code set 2 frames, tracks make/break/shift state, translates
// make codes to 7-bit ASCII and buffers them in a small FIFO read by the MMU.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//   TIMEOUT clk cycles without a ps2clk fall before a partial frame is dropped
// Ports:
//   clk      main clock, rising edge
//   rst      asynchronous active-low reset
//   ps2clk   raw keyboard clock (asynchronous)
//   ps2data  raw keyboard data (asynchronous)
//   pop      consumer strobe, removes the head entry
//   data     ASCII of the head entry, 0 when empty
//   status   1 when the FIFO holds at least one entry
//   overflow sticky drop flag, cleared by pop or reset
module ps2_key_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic       pop,
  output logic [6:0] data,
  output logic       status,
  output logic       overflow
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } state_t;

  // ---------------------------------------------------------------- sync
  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b0;
      dat_s2   <= 1'b0;
    end else begin
      clk_s1   <= ps2clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // ------------------------------------------------------- frame receiver
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;     // start, D0..D7, parity
  logic [15:0] idle_cnt;
  logic        byte_vld;
  logic [7:0]  rx_byte;
  logic        frame_ok;

  // Checked while the stop bit is on the synchronised data line.
  assign frame_ok = ~shreg[0] & dat_s2 & (^shreg[9:1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
      byte_vld <= 1'b0;
      rx_byte  <= '0;
    end else begin
      byte_vld <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt  <= '0;
          byte_vld <= frame_ok;
          rx_byte  <= shreg[8:1];
        end else begin
          shreg[bit_cnt] <= dat_s2;
          bit_cnt        <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == IDLE_MAX) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // -------------------------------------------------------------- mapping
  logic [6:0] lc_char;
  logic       is_letter;
  logic       map_hit;
  logic [6:0] map_char;

  always_comb begin
    lc_char   = '0;
    is_letter = 1'b1;
    map_hit   = 1'b1;
    case (rx_byte)
      8'h1C: lc_char = 7'h61;  8'h32: lc_char = 7'h62;
      8'h21: lc_char = 7'h63;  8'h23: lc_char = 7'h64;
      8'h24: lc_char = 7'h65;  8'h2B: lc_char = 7'h66;
      8'h34: lc_char = 7'h67;  8'h33: lc_char = 7'h68;
      8'h43: lc_char = 7'h69;  8'h3B: lc_char = 7'h6A;
      8'h42: lc_char = 7'h6B;  8'h4B: lc_char = 7'h6C;
      8'h3A: lc_char = 7'h6D;  8'h31: lc_char = 7'h6E;
      8'h44: lc_char = 7'h6F;  8'h4D: lc_char = 7'h70;
      8'h15: lc_char = 7'h71;  8'h2D: lc_char = 7'h72;
      8'h1B: lc_char = 7'h73;  8'h2C: lc_char = 7'h74;
      8'h3C: lc_char = 7'h75;  8'h2A: lc_char = 7'h76;
      8'h1D: lc_char = 7'h77;  8'h22: lc_char = 7'h78;
      8'h35: lc_char = 7'h79;  8'h1A: lc_char = 7'h7A;
      default: begin
        is_letter = 1'b0;
        case (rx_byte)
          8'h45: lc_char = 7'h30;  8'h16: lc_char = 7'h31;
          8'h1E: lc_char = 7'h32;  8'h26: lc_char = 7'h33;
          8'h25: lc_char = 7'h34;  8'h2E: lc_char = 7'h35;
          8'h36: lc_char = 7'h36;  8'h3D: lc_char = 7'h37;
          8'h3E: lc_char = 7'h38;  8'h46: lc_char = 7'h39;
          8'h29: lc_char = 7'h20;  8'h5A: lc_char = 7'h0D;
          8'h66: lc_char = 7'h08;
          default: map_hit = 1'b0;
        endcase
      end
    endcase
  end

  // --------------------------------------------------------- decoder FSM
  state_t state, state_n;
  logic   shl, shr, shl_n, shr_n;
  logic   push;

  assign map_char = (is_letter && (shl || shr)) ? (lc_char - 7'h20) : lc_char;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shl   <= 1'b0;
      shr   <= 1'b0;
    end else begin
      state <= state_n;
      shl   <= shl_n;
      shr   <= shr_n;
    end
  end

  always_comb begin
    state_n = state;
    shl_n   = shl;
    shr_n   = shr;
    push    = 1'b0;
    if (byte_vld) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hF0) begin
            state_n = BREAK;
          end else if (rx_byte == 8'hE0) begin
            state_n = EXT;
          end else begin
            if (rx_byte == 8'h12) shl_n = 1'b1;
            if (rx_byte == 8'h59) shr_n = 1'b1;
            push = map_hit;
          end
        end
        BREAK: begin
          if (rx_byte == 8'h12) shl_n = 1'b0;
          if (rx_byte == 8'h59) shr_n = 1'b0;
          state_n = IDLE;
        end
        EXT:       state_n = (rx_byte == 8'hF0) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- FIFO
  logic [6:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= map_char;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && full && !do_pop)
        overflow <= 1'b1;
      else if (pop && !(push && full))
        overflow <= 1'b0;
    end
  end

  assign status = !empty;
  assign data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
